halfband_interp_feed: RTL and testbench

Upstream feeder for the second-stage halfband filter when it runs as a 2x interpolator. Accepts samples from the previous stage as an asynchronous-rate valid stream and buffers them in a 4-deep FIFO. Generates the filter's sample-rate and double-rate clock enables, zero-stuffs the stream to double rate, and applies a saturating power-of-two gain that restores the interpolation loss. Reports FIFO level and sticky underflow/overflow status to the control register block.

---
 rtl/halfband_interp_feed.sv | 195 +++++++++++++++++++
 tb/tb_halfband_interp_feed.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/halfband_interp_feed.sv
// halfband_interp_feed: 4-deep sample FIFO feeding a 2x halfband interpolator.
// Generates sample/double-rate enables, zero-stuffs and applies saturating gain.
//
// Ports:
//   sys_clk, reset      clock, async active-high reset
//   x_in, x_valid       input sample stream (one-cycle strobe per sample)
//   clear_flags         sync clear of underflow/overflow/drop_cnt
//   y_out               zero-stuffed, gain-scaled output sample (registered)
//   sam_clk_en          pulse per real (even-phase) output
//   sys_clk2_en         pulse per double-rate output (both phases)
//   running             high while in RUN
//   fifo_level          FIFO occupancy 0..4
//   underflow/overflow  sticky status flags
//   drop_cnt            saturating count of dropped pushes
module halfband_interp_feed #(
  parameter int WIDTH      = 18,
  parameter int CLK_DIV    = 4,
  parameter int GAIN_SHIFT = 1,
  parameter int PRIME      = 2
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic             x_valid,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] y_out,
  output logic             sam_clk_en,
  output logic             sys_clk2_en,
  output logic             running,
  output logic [2:0]       fifo_level,
  output logic             underflow,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int EW = WIDTH + 3;

  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_ODD  = PW'(CLK_DIV - 1);

  localparam logic signed [EW-1:0] SMAX =
    {{4{1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN =
    {{4{1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;

  logic [PW-1:0]    ph_cnt;
  logic [WIDTH-1:0] mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;

  logic even_ph;
  logic odd_ph;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;
  logic uf_ev;

  logic [WIDTH-1:0]        head;
  logic signed [EW-1:0]    ext;
  logic signed [EW-1:0]    shifted;
  logic [WIDTH-1:0]        sat_val;

  // ph_cnt holds the phase of the edge just taken; these decode the
  // phase the coming edge will move into.
  assign even_ph = (ph_cnt == PH_LAST);
  assign odd_ph  = (ph_cnt == PH_ODD);

  assign full  = (fifo_level == 3'd4);
  assign empty = (fifo_level == 3'd0);

  // Priming pop and the steady-state pop both happen on even edges only.
  assign pop = even_ph &&
               (((state == IDLE) && (fifo_level >= 3'(PRIME))) ||
                ((state == RUN) && !empty));

  // A full FIFO still accepts a push when it pops on the same edge.
  assign push  = x_valid && (!full || pop);
  assign drop  = x_valid && full && !pop;
  assign uf_ev = even_ph && (state == RUN) && empty;

  assign head    = mem[rd_ptr];
  assign ext     = {{3{head[WIDTH-1]}}, head};
  assign shifted = ext <<< GAIN_SHIFT;

  always_comb begin
    sat_val = shifted[WIDTH-1:0];
    if (shifted > SMAX) begin
      sat_val = SMAX[WIDTH-1:0];
    end else if (shifted < SMIN) begin
      sat_val = SMIN[WIDTH-1:0];
    end
  end

  // Sample storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= x_in;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ph_cnt      <= PH_LAST;
      state       <= IDLE;
      running     <= 1'b0;
      y_out       <= '0;
      sam_clk_en  <= 1'b0;
      sys_clk2_en <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      ph_cnt      <= even_ph ? '0 : ph_cnt + PW'(1);
      sys_clk2_en <= even_ph | odd_ph;
      sam_clk_en  <= even_ph;

      if (even_ph) begin
        y_out <= pop ? sat_val : '0;
      end else if (odd_ph) begin
        y_out <= '0;
      end

      if (even_ph) begin
        unique case (state)
          IDLE: begin
            if (fifo_level >= 3'(PRIME)) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (empty) begin
              state   <= IDLE;
              running <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end

      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end

      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 3'd1;
        2'b01:   fifo_level <= fifo_level - 3'd1;
        default: fifo_level <= fifo_level;
      endcase

      // A new event on the clearing edge takes precedence over the clear.
      if (uf_ev) begin
        underflow <= 1'b1;
      end else if (clear_flags) begin
        underflow <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end

      if (drop) begin
        if (clear_flags) begin
          drop_cnt <= 8'd1;
        end else if (drop_cnt != 8'hff) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (clear_flags) begin
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_halfband_interp_feed.sv
// Testbench for halfband_interp_feed: reference model with a sample queue,
// table-driven stream/saturation vectors and hand-written corner sequences.
module tb_halfband_interp_feed;

  localparam int W   = 18;
  localparam int CD  = 4;
  localparam int GS  = 1;
  localparam int PR  = 2;
  localparam int PER = 2 * CD;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic         sys_clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] x_in = '0;
  logic         x_valid = 1'b0;
  logic         clear_flags = 1'b0;
  logic [W-1:0] y_out;
  logic         sam_clk_en;
  logic         sys_clk2_en;
  logic         running;
  logic [2:0]   fifo_level;
  logic         underflow;
  logic         overflow;
  logic [7:0]   drop_cnt;

  halfband_interp_feed #(
    .WIDTH(W), .CLK_DIV(CD), .GAIN_SHIFT(GS), .PRIME(PR)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .x_in(x_in),
    .x_valid(x_valid),
    .clear_flags(clear_flags),
    .y_out(y_out),
    .sam_clk_en(sam_clk_en),
    .sys_clk2_en(sys_clk2_en),
    .running(running),
    .fifo_level(fifo_level),
    .underflow(underflow),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: samples in a queue, phase derived from edge count.
  int q[$];
  int t;
  bit m_run, m_uf, m_of, m_s2, m_sen;
  int m_dc, m_y;

  function automatic int sat_gain(int x);
    longint v;
    v = longint'(x) * (longint'(1) << GS);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return int'(v);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0d, %0t)",
               nm, act, exp, t, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    t = 0;
    m_run = 0; m_uf = 0; m_of = 0; m_s2 = 0; m_sen = 0;
    m_dc = 0; m_y = 0;
  endtask

  task automatic model_edge(bit xv, int xi, bit clr);
    bit even, odd, pop, ufe, drp;
    int n;
    even = (t % PER) == 0;
    odd  = (t % PER) == CD;
    pop = 0; ufe = 0; drp = 0;
    n = q.size();
    if (even) begin
      if (!m_run) begin
        if (n >= PR) begin m_run = 1; pop = 1; end
      end else if (n == 0) begin
        m_run = 0; ufe = 1;
      end else begin
        pop = 1;
      end
    end
    if (even) m_y = pop ? sat_gain(q[0]) : 0;
    else if (odd) m_y = 0;
    if (pop) void'(q.pop_front());
    if (xv) begin
      if (n < 4 || pop) q.push_back(xi);
      else drp = 1;
    end
    if (ufe) m_uf = 1; else if (clr) m_uf = 0;
    if (drp) m_of = 1; else if (clr) m_of = 0;
    if (drp) m_dc = clr ? 1 : (m_dc < 255 ? m_dc + 1 : 255);
    else if (clr) m_dc = 0;
    m_s2 = even | odd;
    m_sen = even;
    t++;
  endtask

  task automatic compare_all();
    chk("y_out", $signed(y_out), m_y);
    chk("sys_clk2_en", int'(sys_clk2_en), int'(m_s2));
    chk("sam_clk_en", int'(sam_clk_en), int'(m_sen));
    chk("running", int'(running), int'(m_run));
    chk("fifo_level", int'(fifo_level), q.size());
    chk("underflow", int'(underflow), int'(m_uf));
    chk("overflow", int'(overflow), int'(m_of));
    chk("drop_cnt", int'(drop_cnt), m_dc);
  endtask

  task automatic step(bit xv, int xi, bit clr);
    x_valid = xv;
    x_in = xi[W-1:0];
    clear_flags = clr;
    @(posedge sys_clk);
    model_edge(xv, xi, clr);
    #1;
    x_valid = 1'b0;
    clear_flags = 1'b0;
    compare_all();
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_y"}, $signed(y_out), 0);
    chk({tag, "_s2"}, int'(sys_clk2_en), 0);
    chk({tag, "_sen"}, int'(sam_clk_en), 0);
    chk({tag, "_run"}, int'(running), 0);
    chk({tag, "_lvl"}, int'(fifo_level), 0);
    chk({tag, "_uf"}, int'(underflow), 0);
    chk({tag, "_of"}, int'(overflow), 0);
    chk({tag, "_dc"}, int'(drop_cnt), 0);
  endtask

  task automatic do_reset(string tag);
    reset = 1'b1;
    #1;
    check_reset_vals(tag);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
  endfunction

  typedef struct {
    int x;
    int exp_y;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int k, idx, rate;

    tbl[0] = '{1000, 2000};
    tbl[1] = '{-2000, -4000};
    tbl[2] = '{3000, 6000};
    tbl[3] = '{65536, 131071};
    tbl[4] = '{-70000, -131072};
    tbl[5] = '{65535, 131070};
    tbl[6] = '{-65536, -131072};
    tbl[7] = '{0, 0};

    // Reset then idle: enables cadence, no output, no flags.
    do_reset("rst0");
    for (int i = 0; i < 40; i++) step(0, 0, 0);

    // Steady stream with saturation vectors, then drain into underflow.
    do_reset("rst1");
    k = 0;
    idx = 0;
    for (int c = 0; c < 100; c++) begin
      bit xv;
      xv = (c % PER == 1) && (k < 8);
      step(xv, xv ? tbl[k].x : 0, 0);
      if (xv) k++;
      if (sam_clk_en && running && idx < 8) begin
        chk($sformatf("tbl_y%0d", idx), $signed(y_out), tbl[idx].exp_y);
        idx++;
      end
    end
    chk("tbl_pops", idx, 8);
    chk("drain_uf", int'(underflow), 1);
    chk("drain_run", int'(running), 0);
    chk("drain_y", $signed(y_out), 0);

    // Resume input: re-prime and return to RUN.
    for (int i = 0; i < 30; i++) begin
      bit xv;
      xv = (i == 0) || (i == 8) || (i == 16);
      step(xv, xv ? 500 * (i + 1) : 0, 0);
      if (i == 24) chk("rerun", int'(running), 1);
    end

    // Randomized traffic with varying input rate.
    for (int s = 0; s < 8; s++) begin
      rate = int'($urandom_range(5, 30));
      for (int i = 0; i < 100; i++) begin
        bit xv, clr;
        xv = $urandom_range(0, 99) < rate;
        clr = $urandom_range(0, 39) == 0;
        step(xv, rnd_sample(), clr);
      end
    end

    // Overflow in IDLE: 6 back-to-back pushes, then clear_flags.
    do_reset("rst2");
    for (int i = 0; i < 6; i++) step(1, 100 * (i + 1), 0);
    chk("ovf_lvl", int'(fifo_level), 4);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_dc", int'(drop_cnt), 2);
    chk("ovf_run", int'(running), 0);
    step(0, 0, 1);
    chk("clr_of", int'(overflow), 0);
    chk("clr_dc", int'(drop_cnt), 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("prime_run", int'(running), 1);
    chk("prime_y", $signed(y_out), 200);
    step(1, 700, 0);
    chk("refill_lvl", int'(fifo_level), 4);
    for (int i = 0; i < 6; i++) step(0, 0, 0);

    // Full FIFO with push coinciding with an even-phase pop.
    step(1, 800, 0);
    chk("fpp_lvl", int'(fifo_level), 4);
    chk("fpp_of", int'(overflow), 0);
    chk("fpp_sen", int'(sam_clk_en), 1);
    chk("fpp_y", $signed(y_out), 400);
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // Reset mid-stream clears everything immediately.
    do_reset("rst_mid");
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 99) < 20, rnd_sample(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
